fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V 32-bit core. Holds the PC, fetches one word at a time over a request/response handshake to instruction memory, and presents the instruction to decode with a valid/ready handshake. The held `instr[31:7]` field feeds the immediate extender directly. Redirects are computed here as base + sign-extended immediate, using the extender's output from the branch/jump in decode/execute.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_target.sv | 16 +
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_REQ       = 2'd0,  // presenting a request to instruction memory
        S_WAIT      = 2'd1,  // request accepted, waiting for the response
        S_WAIT_KILL = 2'd2,  // response still owed, but it is on a wrong path
        S_HOLD      = 2'd3   // instruction held for decode
    } fetch_state_e;

    // Canonical NOP: addi x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential PC increment for 32-bit instructions.
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage : fetch_pkg

// File: rtl/pc_target.sv
// Redirect target adder: base + sign-extended immediate, halfword aligned.
module pc_target (
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    output logic [31:0] target_o
);

    logic [31:0] sum;

    // Wrap-around add; bit 0 is cleared so JALR targets are always aligned.
    always_comb begin
        sum      = base_i + imm_i;
        target_o = {sum[31:1], 1'b0};
    end

endmodule : pc_target

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// and hands each fetched word to decode over a valid/ready handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction memory
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    // to decode
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [24:0] imm_o,
    // control-transfer redirect
    input  logic        redirect_i,
    input  logic [31:0] redirect_base_i,
    input  logic [31:0] imm_ext_i
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;

    logic [31:0]  redirect_pc_d;
    logic [31:0]  seq_pc_d;

    pc_target u_pc_target (
        .base_i   (redirect_base_i),
        .imm_i    (imm_ext_i),
        .target_o (redirect_pc_d)
    );

    // Sequential successor of the current PC; wraps naturally at 2^32.
    always_comb begin
        seq_pc_d = pc_q + PC_STEP;
    end

    // Fetch sequencer. Redirect wins over every other event in every state;
    // a response that belongs to a squashed request is consumed in S_WAIT_KILL
    // so that at most one request is ever outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_d;
                        if (imem_ready_i) begin
                            state_q <= S_WAIT_KILL;
                        end
                    end else if (imem_ready_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_d;
                        state_q <= imem_rvalid_i ? S_REQ : S_WAIT_KILL;
                    end else if (imem_rvalid_i) begin
                        instr_q <= imem_rdata_i;
                        state_q <= S_HOLD;
                    end
                end
                S_WAIT_KILL: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_d;
                    end
                    if (imem_rvalid_i) begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_d;
                        state_q <= S_REQ;
                    end else if (instr_ready_i) begin
                        pc_q    <= seq_pc_d;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Outputs come straight from state; the request is masked while reset is
    // asserted so memory never sees a request during the reset cycle. pc_q is
    // frozen throughout S_HOLD, so it doubles as the address of instr_o.
    always_comb begin
        imem_req_o    = (state_q == S_REQ) && !rst_i;
        imem_addr_o   = pc_q;
        instr_valid_o = (state_q == S_HOLD);
        instr_o       = instr_q;
        pc_o          = pc_q;
        imm_o         = instr_q[31:7];
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [24:0] imm;
    logic        redirect;
    logic [31:0] redirect_base;
    logic [31:0] imm_ext;

    int total_cnt = 0;
    int bad_cnt   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ready_i    (imem_ready),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .instr_valid_o   (instr_valid),
        .instr_ready_i   (instr_ready),
        .instr_o         (instr),
        .pc_o            (pc),
        .imm_o           (imm),
        .redirect_i      (redirect),
        .redirect_base_i (redirect_base),
        .imm_ext_i       (imm_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one clock; sample point lies 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [3];
    logic [31:0] w;
    logic [31:0] exp_imm;

    initial begin
        words[0] = 32'h0050_0093;
        words[1] = 32'hFFF1_0113;
        words[2] = 32'h8000_0537;

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_base = 32'h0; imm_ext = 32'h0;

        // Reset state
        step();
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_imm",   {7'b0, imm}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);

        // Three back-to-back fetches at 3-cycle spacing
        imem_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("f%0d_req", i),  {31'b0, imem_req}, 32'h1);
            chk($sformatf("f%0d_addr", i), imem_addr, 32'(4 * i));
            step();
            chk($sformatf("f%0d_wait_req", i), {31'b0, imem_req}, 32'h0);
            chk($sformatf("f%0d_wait_valid", i), {31'b0, instr_valid}, 32'h0);
            imem_rvalid = 1'b1; imem_rdata = words[i];
            step();
            imem_rvalid = 1'b0;
            w = words[i];
            exp_imm = {7'b0, w[31:7]};
            chk($sformatf("f%0d_valid", i), {31'b0, instr_valid}, 32'h1);
            chk($sformatf("f%0d_instr", i), instr, w);
            chk($sformatf("f%0d_pc", i), pc, 32'(4 * i));
            chk($sformatf("f%0d_imm", i), {7'b0, imm}, exp_imm);
            step();
        end

        // Stall decode for 5 cycles in S_HOLD
        chk("stall_addr", imem_addr, 32'h0000_000C);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall%0d_valid", i), {31'b0, instr_valid}, 32'h1);
            chk($sformatf("stall%0d_instr", i), instr, 32'h1234_5678);
            chk($sformatf("stall%0d_pc", i), pc, 32'h0000_000C);
            chk($sformatf("stall%0d_req", i), {31'b0, imem_req}, 32'h0);
        end
        instr_ready = 1'b1;
        step();
        chk("stall_next_addr", imem_addr, 32'h0000_0010);

        // Redirect in S_WAIT, then the stale response arrives and is dropped
        step();
        redirect = 1'b1; redirect_base = 32'h0000_0100; imm_ext = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        chk("kill_req", {31'b0, imem_req}, 32'h0);
        chk("kill_valid", {31'b0, instr_valid}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("kill_drop_valid", {31'b0, instr_valid}, 32'h0);
        chk("kill_addr", imem_addr, 32'h0000_00F8);
        chk("kill_req_back", {31'b0, imem_req}, 32'h1);

        // Redirect in S_REQ while memory is not ready; bit 0 is cleared
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_base = 32'h0000_0040; imm_ext = 32'h0000_0021;
        step();
        redirect = 1'b0;
        chk("req_redir_addr", imem_addr, 32'h0000_0060);
        chk("req_redir_req", {31'b0, imem_req}, 32'h1);

        // Redirect in S_WAIT coinciding with rvalid goes straight back to S_REQ
        imem_ready = 1'b1;
        step();
        redirect = 1'b1; redirect_base = 32'h0000_0200; imm_ext = 32'h0000_0004;
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        step();
        redirect = 1'b0; imem_rvalid = 1'b0;
        chk("wr_addr", imem_addr, 32'h0000_0204);
        chk("wr_req", {31'b0, imem_req}, 32'h1);
        chk("wr_valid", {31'b0, instr_valid}, 32'h0);

        // PC wrap from 0xFFFF_FFFC to 0
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_base = 32'hFFFF_FFF0; imm_ext = 32'h0000_000C;
        step();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hABCD_E0EF;
        step();
        imem_rvalid = 1'b0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'hABCD_E0EF);
        step();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset while holding an instruction
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111;
        instr_ready = 1'b0;
        step();
        imem_rvalid = 1'b0;
        chk("hrst_valid_before", {31'b0, instr_valid}, 32'h1);
        rst = 1'b1;
        step();
        chk("hrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("hrst_instr", instr, 32'h0000_0013);
        chk("hrst_addr", imem_addr, 32'h0000_0000);
        chk("hrst_req", {31'b0, imem_req}, 32'h0);
        rst = 1'b0;
        #1;
        chk("hrst_req_after", {31'b0, imem_req}, 32'h1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_fetch_unit
